// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the multi-cycle execute sequencer.
// Holds the sequencer state type, the unit index constants used for
// unit_enable / unit_ready / unit_result slicing, bundled issue/unit
// structs, and the RISC-V divide special-case constants.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } muldiv_seq_state_type;

  localparam int unit_div   = 0;
  localparam int unit_mul   = 1;
  localparam int unit_clmul = 2;

  localparam int muldiv_xlen = 32;

  localparam logic [muldiv_xlen-1:0] div_overflow_num = 32'h8000_0000;
  localparam logic [muldiv_xlen-1:0] all_ones         = 32'hFFFF_FFFF;

  typedef struct packed {
    logic                   valid;
    logic                   division;
    logic                   mult;
    logic                   bitc;
    logic [3:0]             op;
    logic [muldiv_xlen-1:0] rdata1;
    logic [muldiv_xlen-1:0] rdata2;
    logic [4:0]             waddr;
    logic                   wren;
  } muldiv_seq_in_type;

  typedef struct packed {
    logic [2:0]             unit_enable;
    logic [3:0]             unit_op;
    logic [muldiv_xlen-1:0] unit_rdata1;
    logic [muldiv_xlen-1:0] unit_rdata2;
  } muldiv_seq_out_type;

endpackage

// File: rtl/muldiv_sequencer_watchdog.sv
// Loadable down-counter with an expired flag.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   load          - load load_value into the counter (wins over dec)
//   load_value    - value to arm the counter with
//   dec           - decrement by one; saturates at zero
//   expired       - counter has reached zero
module muldiv_watchdog
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one decoded multi-cycle op (divide, multiply, carry-less
// multiply): stalls the pipeline, launches the selected unit, waits for
// its ready under a watchdog and returns one write-back result.
// Divide-by-zero and signed overflow are answered locally.
// Ports:
//   clock, reset, clear          - clock, sync reset, pipeline flush
//   issue_*                      - decoded instruction from execute
//   unit_enable/op/rdata1/rdata2 - launch pulse and operands to units
//   unit_ready/unit_result       - per-unit completion and results
//   stall                        - hold upstream pipeline
//   done/result/wb_waddr/wb_wren - one-cycle write-back
//   error                        - illegal flags or watchdog timeout
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              issue_valid,
  input  logic              issue_division,
  input  logic              issue_mult,
  input  logic              issue_bitc,
  input  logic [3:0]        issue_op,
  input  logic [XLEN-1:0]   issue_rdata1,
  input  logic [XLEN-1:0]   issue_rdata2,
  input  logic [4:0]        issue_waddr,
  input  logic              issue_wren,
  output logic [2:0]        unit_enable,
  output logic [3:0]        unit_op,
  output logic [XLEN-1:0]   unit_rdata1,
  output logic [XLEN-1:0]   unit_rdata2,
  input  logic [2:0]        unit_ready,
  input  logic [3*XLEN-1:0] unit_result,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [4:0]        wb_waddr,
  output logic              wb_wren,
  output logic              error
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [XLEN-1:0] ovf_num = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_seq_state_type state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [XLEN-1:0] rdata2_q, rdata2_d;
  logic [4:0]      waddr_q, waddr_d;
  logic            wren_q, wren_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            timeout_q, timeout_d;
  logic            error_q, error_d;

  logic [2:0]      flags;
  logic            one_hot;
  logic            accept;
  logic            illegal;
  logic            div_zero;
  logic            div_ovf;
  logic            is_quot;
  logic            fast;
  logic [XLEN-1:0] fast_result;
  logic            ready_sel;
  logic [XLEN-1:0] sel_result;
  logic            expired;
  logic            timed_out;

  assign flags   = {issue_bitc, issue_mult, issue_division};
  assign one_hot = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  assign accept  = (state_q == IDLE) && issue_valid && one_hot && !clear;
  assign illegal = (state_q == IDLE) && issue_valid && !one_hot &&
                   (flags != 3'b000) && !clear;

  // RISC-V divide special cases; ops [0]/[1] return the quotient,
  // [0]/[2] are signed.
  assign is_quot  = issue_op[0] | issue_op[1];
  assign div_zero = (issue_rdata2 == '0);
  assign div_ovf  = (issue_op[0] | issue_op[2]) && (issue_rdata1 == ovf_num) &&
                    (issue_rdata2 == '1);
  assign fast     = issue_division && (div_zero || div_ovf);

  always_comb begin
    if (div_zero) begin
      fast_result = is_quot ? '1 : issue_rdata1;
    end else begin
      fast_result = is_quot ? issue_rdata1 : '0;
    end
  end

  // Only the launched unit's ready and result are looked at.
  assign ready_sel = |(unit_ready & sel_q);

  always_comb begin
    sel_result = '0;
    if (sel_q[unit_div])   sel_result = unit_result[unit_div*XLEN +: XLEN];
    if (sel_q[unit_mul])   sel_result = unit_result[unit_mul*XLEN +: XLEN];
    if (sel_q[unit_clmul]) sel_result = unit_result[unit_clmul*XLEN +: XLEN];
  end

  // Armed during ISSUE so it reads TIMEOUT_CYCLES-1 on the first WAIT cycle
  // and expires on the TIMEOUT_CYCLES-th WAIT cycle.
  muldiv_watchdog #(
    .WIDTH(WD_W)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .load       (state_q == ISSUE),
    .load_value (WD_W'(TIMEOUT_CYCLES - 1)),
    .dec        (state_q == WAIT),
    .expired    (expired)
  );

  assign timed_out = (state_q == WAIT) && !ready_sel && expired && !clear;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      op_q      <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      waddr_q   <= '0;
      wren_q    <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      op_q      <= op_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      waddr_q   <= waddr_d;
      wren_q    <= wren_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    op_d      = op_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    waddr_d   = waddr_q;
    wren_d    = wren_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    error_d   = illegal | timed_out;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = fast ? DONE : ISSUE;
          sel_d     = flags;
          op_d      = issue_op;
          rdata1_d  = issue_rdata1;
          rdata2_d  = issue_rdata2;
          waddr_d   = issue_waddr;
          wren_d    = issue_wren;
          timeout_d = 1'b0;
          if (fast) result_d = fast_result;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ready_sel) begin
          state_d  = DONE;
          result_d = sel_result;
        end else if (timed_out) begin
          state_d   = DONE;
          result_d  = '0;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Outputs
  always_comb begin
    stall       = accept || (state_q == ISSUE) || (state_q == WAIT);
    unit_enable = ((state_q == ISSUE) && !clear) ? sel_q : 3'b000;
    done        = (state_q == DONE) && !clear;
    wb_wren     = done && wren_q && !timeout_q;
    error       = error_q;
    result      = result_q;
    wb_waddr    = waddr_q;
    unit_op     = op_q;
    unit_rdata1 = rdata1_q;
    unit_rdata2 = rdata2_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed expectations.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        issue_valid;
  logic        issue_division;
  logic        issue_mult;
  logic        issue_bitc;
  logic [3:0]  issue_op;
  logic [31:0] issue_rdata1;
  logic [31:0] issue_rdata2;
  logic [4:0]  issue_waddr;
  logic        issue_wren;
  logic [2:0]  unit_enable;
  logic [3:0]  unit_op;
  logic [31:0] unit_rdata1;
  logic [31:0] unit_rdata2;
  logic [2:0]  unit_ready;
  logic [95:0] unit_result;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wb_waddr;
  logic        wb_wren;
  logic        error;

  int assertCount = 0;
  int failCount   = 0;

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(64),
    .XLEN(32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .issue_valid    (issue_valid),
    .issue_division (issue_division),
    .issue_mult     (issue_mult),
    .issue_bitc     (issue_bitc),
    .issue_op       (issue_op),
    .issue_rdata1   (issue_rdata1),
    .issue_rdata2   (issue_rdata2),
    .issue_waddr    (issue_waddr),
    .issue_wren     (issue_wren),
    .unit_enable    (unit_enable),
    .unit_op        (unit_op),
    .unit_rdata1    (unit_rdata1),
    .unit_rdata2    (unit_rdata2),
    .unit_ready     (unit_ready),
    .unit_result    (unit_result),
    .stall          (stall),
    .done           (done),
    .result         (result),
    .wb_waddr       (wb_waddr),
    .wb_wren        (wb_wren),
    .error          (error)
  );

  // Free-running 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one decoded instruction; flags = {bitc, mult, division}
  task automatic applyStimulus(input logic [2:0] flags, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] waddr, input logic wren);
    issue_valid    = 1'b1;
    issue_division = flags[0];
    issue_mult     = flags[1];
    issue_bitc     = flags[2];
    issue_op       = op;
    issue_rdata1   = a;
    issue_rdata2   = b;
    issue_waddr    = waddr;
    issue_wren     = wren;
  endtask

  // Remove the instruction from the issue bus
  task automatic idleInputs();
    issue_valid    = 1'b0;
    issue_division = 1'b0;
    issue_mult     = 1'b0;
    issue_bitc     = 1'b0;
    issue_op       = 4'b0;
    issue_rdata1   = 32'h0;
    issue_rdata2   = 32'h0;
    issue_waddr    = 5'd0;
    issue_wren     = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a divide that resolves locally and check its single-cycle result
  task automatic fastDiv(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected);
    applyStimulus(3'b001, op, a, b, 5'd4, 1'b1);
    #1;
    checkOutput({tag, "_stall"}, 64'(stall), 64'd1);
    tick();
    idleInputs();
    #1;
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_result"}, 64'(result), 64'(expected));
    checkOutput({tag, "_enable"}, 64'(unit_enable), 64'd0);
    checkOutput({tag, "_stall_done"}, 64'(stall), 64'd0);
    tick();
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    clear       = 1'b0;
    unit_ready  = 3'b000;
    unit_result = '0;
    idleInputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_stall", 64'(stall), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_wb", 64'({wb_waddr, wb_wren}), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_unit", 64'({unit_enable, unit_op}), 64'd0);
    checkOutput("rst_rdata1", 64'(unit_rdata1), 64'd0);

    // mul 7*6, ready 3 cycles after the launch pulse
    $display("[TB] mul normal path");
    applyStimulus(3'b010, 4'b0001, 32'd7, 32'd6, 5'd3, 1'b1);
    #1;
    checkOutput("mul_stall_T", 64'(stall), 64'd1);
    tick();
    idleInputs();
    #1;
    checkOutput("mul_enable", 64'(unit_enable), 64'b010);
    checkOutput("mul_operands", 64'({unit_rdata1, unit_rdata2}), {32'd7, 32'd6});
    checkOutput("mul_op", 64'(unit_op), 64'b0001);
    tick();
    unit_ready  = 3'b001;
    unit_result = {32'd0, 32'd42, 32'd99};
    #1;
    checkOutput("mul_enable_once", 64'(unit_enable), 64'd0);
    tick();
    unit_ready = 3'b000;
    #1;
    checkOutput("mul_other_ready_ignored", 64'({stall, done}), 64'b10);
    tick();
    unit_ready = 3'b010;
    #1;
    checkOutput("mul_stall_T4", 64'(stall), 64'd1);
    tick();
    unit_ready = 3'b000;
    #1;
    checkOutput("mul_done", 64'({done, stall, wb_wren, error}), 64'b1010);
    checkOutput("mul_result", 64'(result), 64'd42);
    checkOutput("mul_waddr", 64'(wb_waddr), 64'd3);
    tick();
    checkOutput("mul_done_once", 64'(done), 64'd0);

    // Divide special cases answered without the divider
    $display("[TB] divide fast path");
    fastDiv("divu_zero", 4'b0010, 32'h1234, 32'h0, 32'hFFFF_FFFF);
    fastDiv("remu_zero", 4'b1000, 32'h1234, 32'h0, 32'h1234);
    fastDiv("divs_ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    fastDiv("rem_ovf", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Unsigned divide of the same operands is not a special case
    applyStimulus(3'b001, 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1'b1);
    tick();
    idleInputs();
    #1;
    checkOutput("divu_ovf_launch", 64'(unit_enable), 64'b001);
    tick();
    unit_ready  = 3'b001;
    unit_result = {32'd0, 32'd0, 32'd0};
    tick();
    unit_ready = 3'b000;
    #1;
    checkOutput("divu_min_latency", 64'({done, wb_wren}), 64'b11);
    tick();

    // clmul never answers: watchdog fires after 64 WAIT cycles
    $display("[TB] watchdog timeout");
    applyStimulus(3'b100, 4'b0001, 32'h5, 32'h3, 5'd9, 1'b1);
    tick();
    idleInputs();
    #1;
    checkOutput("clmul_enable", 64'(unit_enable), 64'b100);
    tick();
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", 64'(n), 64'd64);
    checkOutput("timeout_flags", 64'({done, error, wb_wren}), 64'b110);
    checkOutput("timeout_result", 64'(result), 64'd0);
    tick();
    checkOutput("timeout_idle", 64'({done, error, stall}), 64'b000);

    // clear during WAIT, late ready must be ignored
    $display("[TB] clear in WAIT");
    applyStimulus(3'b001, 4'b0010, 32'd100, 32'd7, 5'd6, 1'b1);
    tick();
    idleInputs();
    tick();
    tick();
    clear = 1'b1;
    #1;
    checkOutput("clear_cycle", 64'({stall, done}), 64'b10);
    tick();
    clear = 1'b0;
    #1;
    checkOutput("clear_stall_drop", 64'(stall), 64'd0);
    tick();
    unit_ready  = 3'b001;
    unit_result = {32'd0, 32'd0, 32'd14};
    #1;
    checkOutput("late_ready", 64'({done, stall, error}), 64'b000);
    tick();
    unit_ready = 3'b000;
    #1;
    checkOutput("late_ready_after", 64'({done, unit_enable}), 64'd0);

    applyStimulus(3'b010, 4'b1000, 32'd3, 32'd5, 5'd7, 1'b1);
    tick();
    idleInputs();
    tick();
    unit_ready  = 3'b010;
    unit_result = {32'd0, 32'd15, 32'd0};
    tick();
    unit_ready = 3'b000;
    #1;
    checkOutput("after_clear_done", 64'({done, wb_wren, wb_waddr}), {1'b1, 1'b1, 5'd7});
    checkOutput("after_clear_result", 64'(result), 64'd15);
    tick();

    // Illegal flag combination
    $display("[TB] illegal and clear-vs-accept");
    applyStimulus(3'b011, 4'b0001, 32'd1, 32'd1, 5'd2, 1'b1);
    #1;
    checkOutput("illegal_stall", 64'(stall), 64'd0);
    tick();
    idleInputs();
    #1;
    checkOutput("illegal_error", 64'({error, unit_enable, stall}), {1'b1, 3'b000, 1'b0});
    tick();
    checkOutput("illegal_error_once", 64'({error, unit_enable, stall}), 64'd0);

    // No unit flag: ignored
    applyStimulus(3'b000, 4'b0001, 32'd1, 32'd1, 5'd2, 1'b1);
    #1;
    checkOutput("noflag_stall", 64'(stall), 64'd0);
    tick();
    idleInputs();
    #1;
    checkOutput("noflag_ignored", 64'({error, unit_enable, done}), 64'd0);

    // clear beats a same-cycle accept
    applyStimulus(3'b010, 4'b0001, 32'd2, 32'd2, 5'd2, 1'b1);
    clear = 1'b1;
    #1;
    checkOutput("clear_accept_stall", 64'(stall), 64'd0);
    tick();
    clear = 1'b0;
    idleInputs();
    #1;
    checkOutput("clear_accept_none", 64'({unit_enable, stall}), 64'd0);
    tick();
    checkOutput("clear_accept_nodone", 64'(done), 64'd0);

    // Reset mid-operation
    $display("[TB] reset mid-op");
    applyStimulus(3'b010, 4'b0001, 32'd9, 32'd9, 5'd1, 1'b1);
    tick();
    idleInputs();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midop_reset", 64'({stall, done, error, unit_enable}), 64'd0);
    checkOutput("midop_reset_regs", 64'({unit_rdata1, wb_waddr}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the multi-cycle execute resources flagged by the instruction decoder: divider (division), multiplier (mult), carry-less multiplier (bitc).
- Accepts one decoded multi-cycle op and stalls the pipeline while it runs.
- Launches the selected unit, waits for its ready, and returns a single write-back result.
- Resolves RISC-V divide special cases locally without starting the divider, and guards every launch with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before the op is aborted with an error.
- XLEN, 32, operand and result width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  pipeline flush; aborts any op in flight.
- issue_valid  in  1  decoded instruction present in execute.
- issue_division  in  1  decoder division flag.
- issue_mult  in  1  decoder mult flag.
- issue_bitc  in  1  decoder bitc flag.
- issue_op  in  4  one-hot sub-op:
  - div: [0] divs, [1] divu, [2] rem, [3] remu.
  - mul: [0] muls, [1] mulh, [2] mulhsu, [3] mulhu.
  - clmul: [0] clmul, [1] clmulr, [2] clmulh.
- issue_rdata1  in  XLEN  rs1 value.
- issue_rdata2  in  XLEN  rs2 value.
- issue_waddr  in  5  destination register.
- issue_wren  in  1  destination write enable.
- unit_enable  out  3  one-cycle launch pulse: [0] div, [1] mul, [2] clmul.
- unit_op  out  4  registered issue_op.
- unit_rdata1  out  XLEN  registered rs1.
- unit_rdata2  out  XLEN  registered rs2.
- unit_ready  in  3  per-unit completion strobe.
- unit_result  in  3*XLEN  per-unit result, unit k in bits [k*XLEN +: XLEN].
- stall  out  1  hold upstream pipeline.
- done  out  1  result valid, one cycle.
- result  out  XLEN  write-back data.
- wb_waddr  out  5  write-back register.
- wb_wren  out  1  write-back enable, qualified by done.
- error  out  1  one-cycle pulse: illegal flag combination or watchdog timeout.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset:
  - state=IDLE.
  - All outputs 0: unit_enable, stall, done, result, wb_waddr, wb_wren, error.
  - unit_op and operand registers are 0; watchdog counter is 0.
- IDLE accept (cycle T): issue_valid=1 and exactly one of division/mult/bitc is set.
  - stall=1 combinationally in cycle T.
  - Register op, operands, waddr and wren.
- Fast path (divider only; next state DONE, unit_enable never pulses):
  - rs2==0: quotient = all ones; remainder = rs1.
  - divs/rem with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = rs1; remainder = 0.
- Normal path:
  - T+1 ISSUE: unit_enable[sel] pulses for one cycle with registered operands; then go to WAIT.
  - WAIT: sample unit_ready[sel] only; ready on other bits is ignored.
  - When ready is sampled, capture unit_result[sel] and go to DONE.
  - Minimum latency: ready in T+2 gives done in T+3.
- DONE (one cycle):
  - done=1, stall=0, result/wb_waddr valid.
  - wb_wren = registered issue_wren.
  - Next state IDLE.
- stall=1 in ISSUE and WAIT, and in the IDLE accept cycle; 0 otherwise.
- Watchdog:
  - Counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready: go to DONE with result=0, wb_wren=0, error=1.
- Illegal input: issue_valid with two or more unit flags set.
  - Pulse error for one cycle; no launch, no stall; stay in IDLE.
- issue_valid with no unit flag: ignored.
- clear:
  - Valid in any state; next state is IDLE, with stall=0 from the next cycle.
  - Suppresses unit_enable and done in the clear cycle.
  - In the same cycle as an IDLE accept, clear wins: nothing is accepted.
  - A unit_ready arriving later for an aborted op is ignored because it arrives in IDLE.
- issue_valid outside IDLE is ignored; upstream is held by stall.
- Reset mid-operation returns to IDLE with all outputs cleared in the next cycle.

Decomposition:
- Shared package (wires/constants):
  - typedef muldiv_seq_state_type.
  - unit index constants unit_div=0, unit_mul=1, unit_clmul=2.
  - muldiv_seq_in_type / muldiv_seq_out_type structs.
  - Constants div_overflow_num=32'h80000000 and all_ones.
- Sub-module muldiv_watchdog: loadable down-counter with an expired flag, reusable by other multi-cycle units.

Test Plan:
1. mul, rs1=7, rs2=6; unit_ready[1] 3 cycles after the enable pulse with result 42 -> enable[1] in T+1; stall high T..T+4; done in T+5 with result=42, wb_wren=1.
2. divu, rs2=0, rs1=0x1234 -> no enable; done in T+1 with result=0xFFFFFFFF. Repeat as remu -> result=0x1234.
3. divs, rs1=0x80000000, rs2=0xFFFFFFFF -> done in T+1 with result=0x80000000. Repeat as rem -> result=0.
4. clmul with unit_ready held low, TIMEOUT_CYCLES=64 -> done and error pulse after 64 WAIT cycles, result=0, wb_wren=0; then back in IDLE.
5. clear asserted in WAIT, then unit_ready[0] arrives 2 cycles later -> stall drops the cycle after clear; no done; the ready is ignored. A new mul issued afterwards completes normally.
6. issue_valid with division=1 and mult=1 -> single error pulse, no enable, stall=0. A simultaneous clear+issue in IDLE -> nothing accepted.
